// File: rtl/rom_loader_pkg.sv
// Shared constants and frame-FSM state encoding for the serial ROM loader.
package rom_loader_pkg;
  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         BYTES_PER_WORD = 3;

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM} state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, framing-error detect.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       ferr
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t        st;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
      case (st)
        // Only reachable with the line high, so a low level here is the falling edge.
        RX_IDLE: begin
          if (!rx_sync) begin
            cnt <= '0;
            st  <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) st <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
              st         <= RX_IDLE;
            end else begin
              ferr <= 1'b1;
              st   <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: if (rx_sync) st <= RX_IDLE;
        default:      st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/rom_serial_loader.sv
// Parses framed program images from the serial link and streams words into the ROM load port.
module rom_serial_loader
  import rom_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 17,
  parameter int TIMEOUT_CLKS = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              rom_load,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  logic [7:0] byte_data;
  logic       byte_valid, ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .ferr       (ferr)
  );

  state_t            state;
  logic [6:0]        len_hi;
  logic [14:0]       len, word_cnt;
  logic [1:0]        byte_idx;
  logic [7:0]        sum, b1;
  logic              b0_lsb;
  logic [ADDR_W-1:0] addr;
  logic [TMO_W-1:0]  tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len_hi   <= '0;
      len      <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      sum      <= '0;
      b0_lsb   <= 1'b0;
      b1       <= '0;
      addr     <= '0;
      tmo_cnt  <= '0;
      rom_addr <= '0;
      rom_data <= '0;
      rom_load <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rom_load <= 1'b0;
      if (state == IDLE || byte_valid) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;

      // Abort keeps whatever was already written; there is no rollback.
      if (state != IDLE && (ferr || (!byte_valid && tmo_cnt == TMO_LAST))) begin
        err   <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
      end else if (byte_valid) begin
        case (state)
          IDLE: begin
            if (byte_data == SYNC_BYTE) begin
              busy  <= 1'b1;
              done  <= 1'b0;
              err   <= 1'b0;
              addr  <= '0;
              sum   <= '0;
              state <= LEN_HI;
            end
          end
          LEN_HI: begin
            len_hi <= byte_data[6:0];
            state  <= LEN_LO;
          end
          LEN_LO: begin
            len      <= {len_hi, byte_data};
            word_cnt <= '0;
            byte_idx <= '0;
            state    <= ({len_hi, byte_data} == 15'd0) ? CSUM : DATA;
          end
          DATA: begin
            sum <= sum + byte_data;
            if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
              rom_load <= 1'b1;
              rom_addr <= addr;
              rom_data <= DATA_W'({b0_lsb, b1, byte_data});
              addr     <= addr + 1'b1;
              word_cnt <= word_cnt + 15'd1;
              byte_idx <= '0;
              if (word_cnt + 15'd1 == len) state <= CSUM;
            end else begin
              if (byte_idx == 2'd0) b0_lsb <= byte_data[0];
              else b1 <= byte_data;
              byte_idx <= byte_idx + 1'b1;
            end
          end
          CSUM: begin
            if (byte_data == sum) done <= 1'b1;
            else err <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rom_serial_loader.sv
// Self-checking bench for rom_serial_loader: serial frames in, ROM writes and status out.
module tb_rom_serial_loader;
  localparam int CPB = 8;
  localparam int AW  = 15;
  localparam int DW  = 17;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_load, busy, done, err;

  rom_serial_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_load(rom_load),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int bv_count = 0;

  logic [AW-1:0] ld_addr_q[$];
  logic [DW-1:0] ld_data_q[$];
  logic [7:0]    frame_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic          exp_good;

  always @(negedge clk) begin
    if (rom_load) begin
      ld_addr_q.push_back(rom_addr);
      ld_data_q.push_back(rom_data);
    end
    if (dut.u_rx.byte_valid) bv_count++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
  endtask

  task automatic clear_loads();
    ld_addr_q.delete();
    ld_data_q.delete();
  endtask

  // Reference model: builds a frame of n random words and the writes it must produce.
  task automatic build_random(input int n, input logic good);
    logic [7:0]  sum, b0, hi_r;
    logic [16:0] w;
    frame_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    sum  = 8'd0;
    hi_r = 8'($urandom);
    frame_q.push_back(8'hA5);
    frame_q.push_back({hi_r[7], 7'(n >> 8)});
    frame_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w  = 17'($urandom);
      b0 = 8'($urandom);
      b0[0] = w[16];
      frame_q.push_back(b0);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      sum = sum + b0 + w[15:8] + w[7:0];
      exp_addr_q.push_back(AW'(i));
      exp_data_q.push_back(w);
    end
    if (good) frame_q.push_back(sum);
    else frame_q.push_back(sum + 8'd1 + 8'($urandom_range(0, 254)));
    exp_good = good;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rom_addr, rom_data, rom_load, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%h data=%h load=%b busy=%b done=%b err=%b want all 0",
               rom_addr, rom_data, rom_load, busy, done, err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [7:0] f[10] = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00};
    clear_loads();
    send_byte(f[0], 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL good_busy_after_sync got %b want 1", busy);
    end
    for (int i = 1; i < 10; i++) send_byte(f[i], 1'b1);
    checks++;
    if (ld_addr_q.size() != 2) begin
      failures++;
      $display("FAIL good_load_count got %0d want 2", ld_addr_q.size());
    end else begin
      checks++;
      if (ld_addr_q[0] !== 15'd0 || ld_data_q[0] !== 17'h00001) begin
        failures++;
        $display("FAIL good_word0 got %h/%h want 0000/00001", ld_addr_q[0], ld_data_q[0]);
      end
      checks++;
      if (ld_addr_q[1] !== 15'd1 || ld_data_q[1] !== 17'h1FFFF) begin
        failures++;
        $display("FAIL good_word1 got %h/%h want 0001/1ffff", ld_addr_q[1], ld_data_q[1]);
      end
    end
    checks++;
    if ({busy, done, err} !== 3'b010) begin
      failures++;
      $display("FAIL good_status got busy/done/err=%b%b%b want 010", busy, done, err);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[10] = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h01};
    clear_loads();
    for (int i = 0; i < 10; i++) send_byte(f[i], 1'b1);
    checks++;
    if (ld_addr_q.size() != 2) begin
      failures++;
      $display("FAIL badcsum_load_count got %0d want 2", ld_addr_q.size());
    end
    checks++;
    if ({busy, done, err} !== 3'b001) begin
      failures++;
      $display("FAIL badcsum_status got busy/done/err=%b%b%b want 001", busy, done, err);
    end
  endtask

  task automatic test_noise_then_empty();
    clear_loads();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    checks++;
    if ({busy, err} !== 2'b01) begin
      failures++;
      $display("FAIL noise_ignored got busy/err=%b%b want 01", busy, err);
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL empty_busy_midframe got %b want 1", busy);
    end
    send_byte(8'h00, 1'b1);
    checks++;
    if ({busy, done, err} !== 3'b010 || ld_addr_q.size() != 0) begin
      failures++;
      $display("FAIL empty_frame got busy/done/err=%b%b%b loads=%0d want 010 loads=0",
               busy, done, err, ld_addr_q.size());
    end
  endtask

  task automatic test_timeout();
    logic [7:0] f[8] = '{8'hA5, 8'h80, 8'h03, 8'h01, 8'h12, 8'h34, 8'h00, 8'h56};
    clear_loads();
    for (int i = 0; i < 8; i++) send_byte(f[i], 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_busy_before_expiry got %b want 1", busy);
    end
    repeat (TMO + 10) @(negedge clk);
    checks++;
    if ({busy, done, err} !== 3'b001 || ld_addr_q.size() != 1) begin
      failures++;
      $display("FAIL timeout_abort got busy/done/err=%b%b%b loads=%0d want 001 loads=1",
               busy, done, err, ld_addr_q.size());
    end
    checks++;
    if (ld_addr_q.size() == 1 && ld_data_q[0] !== 17'h11234) begin
      failures++;
      $display("FAIL timeout_first_word got %h want 11234", ld_data_q[0]);
    end
    clear_loads();
    build_random(2, 1'b1);
    send_frame();
    checks++;
    if (ld_addr_q.size() != 2 || ld_addr_q[0] !== 15'd0 || ld_data_q[0] !== exp_data_q[0] ||
        ld_addr_q[1] !== 15'd1 || ld_data_q[1] !== exp_data_q[1] || done !== 1'b1) begin
      failures++;
      $display("FAIL timeout_recovery got loads=%0d done=%b want 2 writes from addr 0 done=1",
               ld_addr_q.size(), done);
    end
  endtask

  task automatic test_ferr_and_glitch();
    int bv_before;
    clear_loads();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b0);
    checks++;
    if ({busy, done, err} !== 3'b001 || ld_addr_q.size() != 0) begin
      failures++;
      $display("FAIL ferr_abort got busy/done/err=%b%b%b loads=%0d want 001 loads=0",
               busy, done, err, ld_addr_q.size());
    end
    bv_before = bv_count;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checks++;
    if (bv_count != bv_before) begin
      failures++;
      $display("FAIL glitch_byte_valid got %0d pulses want 0", bv_count - bv_before);
    end
    build_random(0, 1'b1);
    send_frame();
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL after_glitch_frame got done/err=%b%b want 10", done, err);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[6] = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'hAB, 8'hCD};
    for (int i = 0; i < 6; i++) send_byte(f[i], 1'b1);
    clear_loads();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rom_addr, rom_data, rom_load, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL async_reset got addr=%h data=%h load=%b busy=%b done=%b err=%b want all 0",
               rom_addr, rom_data, rom_load, busy, done, err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ld_addr_q.size() != 0) begin
      failures++;
      $display("FAIL reset_no_load got %0d loads want 0", ld_addr_q.size());
    end
    build_random(1, 1'b1);
    send_frame();
    checks++;
    if (ld_addr_q.size() != 1 || ld_addr_q[0] !== 15'd0 || ld_data_q[0] !== exp_data_q[0]) begin
      failures++;
      $display("FAIL reset_recovery got loads=%0d want one write at addr 0 data %h",
               ld_addr_q.size(), exp_data_q[0]);
    end
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 5; t++) begin
      clear_loads();
      build_random($urandom_range(1, 6), logic'($urandom_range(0, 1)));
      send_frame();
      checks++;
      if (ld_addr_q.size() != exp_addr_q.size()) begin
        failures++;
        $display("FAIL rand%0d_load_count got %0d want %0d", t, ld_addr_q.size(), exp_addr_q.size());
      end else begin
        for (int i = 0; i < exp_addr_q.size(); i++) begin
          checks++;
          if (ld_addr_q[i] !== exp_addr_q[i] || ld_data_q[i] !== exp_data_q[i]) begin
            failures++;
            $display("FAIL rand%0d_word%0d got %h/%h want %h/%h", t, i,
                     ld_addr_q[i], ld_data_q[i], exp_addr_q[i], exp_data_q[i]);
          end
        end
      end
      checks++;
      if ({busy, done, err} !== {1'b0, exp_good, !exp_good}) begin
        failures++;
        $display("FAIL rand%0d_status got busy/done/err=%b%b%b want 0%b%b", t,
                 busy, done, err, exp_good, !exp_good);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_noise_then_empty();
    test_timeout();
    test_ferr_and_glitch();
    test_reset_mid_frame();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_serial_loader.md
Name: rom_serial_loader

Overview:
- Writer side of the HACK program-ROM load interface: receives a framed program image over the AVR serial link (8N1, FPGA Rx).
- Drives address, data and a write strobe into the ROM load port, one word at a time.
- Sits between the AVR serial pins and the HACK computer's ROM port.
- busy is used at top level to hold the CPU in reset while the image streams in.

Parameters:
- CLKS_PER_BIT, 100, clk cycles per serial bit (50 MHz / 500 kbaud); must be ≥ 4.
- ADDR_W, 15, ROM address width.
- DATA_W, 17, ROM data width; always 3 bytes per word on the wire.
- TIMEOUT_CLKS, 5_000_000, idle clocks between bytes mid-frame before abort (100 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input from AVR Tx, idle high, asynchronous to clk.
- rom_addr  out  ADDR_W  write address to ROM load port.
- rom_data  out  DATA_W  write data to ROM load port.
- rom_load  out  1  one-cycle write strobe.
- busy  out  1  high while a frame is in progress.
- done  out  1  sticky: last frame completed with good checksum.
- err  out  1  sticky: last frame aborted or checksum bad.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM=IDLE, byte/word counters 0, rx synchroniser flops = 1.
- UART receive:
  - rx passes through a 2-flop synchroniser.
  - A falling edge in idle starts a bit timer. The start bit is re-checked at CLKS_PER_BIT/2; if it reads 1 it is a glitch and the receiver returns to idle.
  - Data bits are sampled LSB-first at each bit centre.
  - Stop bit sampled at its centre:
    - 1 → byte_valid pulse for one cycle.
    - 0 → ferr pulse, byte discarded, receiver waits for rx=1 before re-arming.
- Frame format: 0xA5, LEN_HI, LEN_LO, N×(B0,B1,B2), CSUM.
  - N = {LEN_HI[6:0], LEN_LO}; LEN_HI[7] is ignored.
  - Word = {B0[0], B1, B2}; B0[7:1] are ignored.
  - CSUM = 8-bit modulo sum of all data bytes B0..B2 of every word (sync and length bytes excluded).
- FSM states: IDLE → LEN_HI → LEN_LO → DATA → CSUM → IDLE.
  - IDLE: bytes other than 0xA5 are ignored; ferr is ignored. On 0xA5: busy=1, done=0, err=0, addr=0, sum=0.
  - LEN_LO: if N==0 go to CSUM, else go to DATA.
  - DATA: byte index cycles 0,1,2 and every byte is added to sum.
    - On the third byte: the cycle after its byte_valid, rom_addr=addr, rom_data=word, rom_load=1 for exactly one cycle; addr then increments.
    - After N words go to CSUM.
    - rom_addr/rom_data hold their values between strobes.
  - CSUM: received byte == sum → done=1, else err=1. In both cases busy=0 and the FSM returns to IDLE.
- Abort conditions in any non-IDLE state: ferr, or TIMEOUT_CLKS cycles without a byte_valid.
  - Effect: err=1, busy=0, FSM returns to IDLE.
  - Words already written stay written; there is no rollback.
- Timeout counter clears on each byte_valid and is held at 0 in IDLE.
- Address counter is ADDR_W bits and wraps modulo 2^ADDR_W. N ≤ 32767, so a legal frame never wraps.
- A new 0xA5 arriving mid-frame is treated as data, not as a resync.
- Reset mid-frame aborts immediately with outputs at reset values and no rom_load. The next frame starts at addr 0.

Decomposition:
- Package rom_loader_pkg holds:
  - SYNC_BYTE = 8'hA5
  - BYTES_PER_WORD = 3
  - FSM state enum {IDLE, LEN_HI, LEN_LO, DATA, CSUM}
- Sub-module uart_rx_byte (params CLKS_PER_BIT).
  - Inputs: clk, rst, rx.
  - Outputs: byte_data[7:0], byte_valid, ferr.
  - Contains the synchroniser, bit timer and shift register.
- Frame FSM, checksum, counters and timeout live in the top.

Test Plan:
- Good frame A5 00 02 00 00 01 01 FF FF 00 → rom_load at addr 0 data 0x00001, then addr 1 data 0x1FFFF; done=1, err=0, busy falls after the CSUM byte.
- Same frame with CSUM 0x01 → both words are still strobed; err=1, done=0.
- Noise 00 FF 5A, then A5 00 00 00 → no rom_load, done=1; busy is high only from A5 to the final 00.
- Frame with N=3 stalled after B1 of word 1 for TIMEOUT_CLKS+10 cycles → err=1, busy=0, exactly 1 rom_load. A following good frame writes from addr 0.
- Stop bit driven 0 on LEN_LO → err=1, no rom_load. A 1/4-bit low glitch on idle rx → no byte_valid.
- rst pulsed while in DATA → all outputs 0 asynchronously; after release, a good N=1 frame writes addr 0.
